// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Bus bundle for the writeback arbiter. Carries the ALU
//                result stream, the load-data stream and the register file
//                write port.
//                  ALU : alu_valid, alu_rd, alu_data  -> alu_stall
//                  LD  : ld_valid, ld_rd, ld_data, ld_funct3 -> ld_ready
//                  WR  : wr_en, wr_num, wr_data, busy
//                The slave modport is the arbiter; the master modport is the
//                surrounding pipeline (issue/LSU/register file side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_stall;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic [2:0]    ld_funct3;

    logic [AW-1:0] wr_num;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_stall,
        input  ld_valid, ld_rd, ld_data, ld_funct3,
        output ld_ready,
        output wr_num, wr_data, wr_en, busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_stall,
        output ld_valid, ld_rd, ld_data, ld_funct3,
        input  ld_ready,
        input  wr_num, wr_data, wr_en, busy
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback arbiter in front of the register file write port.
//                ALU results (single cycle) take priority; load results are
//                buffered in a 2-entry FIFO and drained whenever no ALU
//                result claims the port. The ALU is stalled only while the
//                FIFO is full, so loads can never starve.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - wb_arbiter_if.slave (ALU, load and write-port groups)
//  Options     : WB_LOAD_EXT_EN - when defined, popped load data is sign- or
//                zero-extended according to its RV32 funct3.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
);

    localparam logic [1:0] c_FULL = 2'd2;

    // FIFO state
    logic [1:0]    count_q, count_d;
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic [AW-1:0] rd_mem_q   [2];
    logic [DW-1:0] data_mem_q [2];

    // Registered write port
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_num_q, wr_num_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic          w_full;
    logic          w_sel_alu;
    logic          w_pop;
    logic          w_push;
    logic          w_sel_valid;
    logic [AW-1:0] w_sel_rd;
    logic [DW-1:0] w_sel_data;
    logic [DW-1:0] w_head_data;

`ifdef WB_LOAD_EXT_EN
    logic [2:0]    f3_mem_q [2];

    function automatic logic [DW-1:0] f_ext(input logic [DW-1:0] d,
                                            input logic [2:0]    f3);
        logic [DW-1:0] r;
        case (f3)
            3'b000:  r = {{(DW-8){d[7]}},   d[7:0]};
            3'b001:  r = {{(DW-16){d[15]}}, d[15:0]};
            3'b100:  r = {{(DW-8){1'b0}},   d[7:0]};
            3'b101:  r = {{(DW-16){1'b0}},  d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign w_head_data = f_ext(data_mem_q[rptr_q], f3_mem_q[rptr_q]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            f3_mem_q[wptr_q] <= bus.ld_funct3;
        end
    end
`else
    // funct3 is carried on the bus but has no effect without extension.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^bus.ld_funct3;
    assign w_head_data     = data_mem_q[rptr_q];
`endif

    // Status is derived from the registered count only, so ld_valid never
    // reaches alu_stall/ld_ready/busy combinationally.
    assign w_full        = (count_q == c_FULL);
    assign bus.ld_ready  = ~w_full;
    assign bus.busy      = (count_q != 2'd0);
    assign bus.alu_stall = bus.alu_valid & w_full;

    assign w_sel_alu = bus.alu_valid & ~w_full;
    assign w_pop     = ~w_sel_alu & (count_q != 2'd0);
    assign w_push    = bus.ld_valid & ~w_full;

    // FIFO payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            rd_mem_q[wptr_q]   <= bus.ld_rd;
            data_mem_q[wptr_q] <= bus.ld_data;
        end
    end

    always_comb begin
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        wr_en_d     = 1'b0;
        wr_num_d    = wr_num_q;
        wr_data_d   = wr_data_q;
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;

        if (w_sel_alu) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = bus.alu_rd;
            w_sel_data  = bus.alu_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = rd_mem_q[rptr_q];
            w_sel_data  = w_head_data;
        end

        // x0 writes are consumed silently; the port keeps its last values.
        if (w_sel_valid && (w_sel_rd != '0)) begin
            wr_en_d   = 1'b1;
            wr_num_d  = w_sel_rd;
            wr_data_d = w_sel_data;
        end

        if (w_push) begin
            wptr_d = ~wptr_q;
        end
        if (w_pop) begin
            rptr_d = ~rptr_q;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_num_q  <= '0;
            wr_data_q <= '0;
        end else begin
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wr_en_q   <= wr_en_d;
            wr_num_q  <= wr_num_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_num  = wr_num_q;
    assign bus.wr_data = wr_data_q;

endmodule
`default_nettype wire
